// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm: sequencing half of the OTTER control unit.
// The decoder chooses what an instruction does. This block chooses when
// each strobe fires: fetch, execute, load writeback and interrupt entry.
module otter_cu_fsm #(
    parameter int INIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       intr,
    input  logic       csr_mie,
    output logic       pc_write,
    output logic       reg_write,
    output logic       mem_rden1,
    output logic       mem_rden2,
    output logic       mem_we2,
    output logic       csr_we,
    output logic       mret_exec,
    output logic       int_taken,
    output logic       rst_out
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_RG3    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYS    = 7'b1110011;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_MRET   = 3'b000;

    // Last value the INIT counter reaches before leaving ST_INIT.
    localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_WB,
        ST_INTR
    } state_t;

    state_t     r_state;
    state_t     w_stateNext;
    logic [3:0] r_initCnt;
    logic [3:0] w_initCntNext;
    logic       w_intrReq;

    // An interrupt is only considered when both the request and the enable are up.
    assign w_intrReq = intr & csr_mie;

    // State and INIT counter registers; reset aborts whatever is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_initCnt <= 4'd0;
        end else begin
            r_state   <= w_stateNext;
            r_initCnt <= w_initCntNext;
        end
    end

    // Next-state selection and Moore strobes decoded from state plus opcode/func3.
    always_comb begin
        w_stateNext   = r_state;
        w_initCntNext = 4'd0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        mem_rden1     = 1'b0;
        mem_rden2     = 1'b0;
        mem_we2       = 1'b0;
        csr_we        = 1'b0;
        mret_exec     = 1'b0;
        int_taken     = 1'b0;
        rst_out       = 1'b0;

        case (r_state)
            ST_INIT: begin
                rst_out = 1'b1;
                if (r_initCnt == INIT_LAST) begin
                    w_stateNext   = ST_FETCH;
                    w_initCntNext = 4'd0;
                end else begin
                    w_initCntNext = r_initCnt + 4'd1;
                end
            end

            ST_FETCH: begin
                mem_rden1   = 1'b1;
                w_stateNext = ST_EXEC;
            end

            ST_EXEC: begin
                w_stateNext = w_intrReq ? ST_INTR : ST_FETCH;
                case (opcode)
                    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RG3: begin
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                    end
                    OP_BRANCH: begin
                        pc_write = 1'b1;
                    end
                    OP_STORE: begin
                        pc_write = 1'b1;
                        mem_we2  = 1'b1;
                    end
                    OP_LOAD: begin
                        mem_rden2   = 1'b1;
                        w_stateNext = ST_WB;
                    end
                    OP_SYS: begin
                        pc_write = 1'b1;
                        if (func3 == F3_CSRRW) begin
                            reg_write = 1'b1;
                            csr_we    = 1'b1;
                        end else if (func3 == F3_MRET) begin
                            mret_exec = 1'b1;
                        end
                    end
                    default: begin
                        pc_write = 1'b1;
                    end
                endcase
            end

            ST_WB: begin
                pc_write    = 1'b1;
                reg_write   = 1'b1;
                w_stateNext = w_intrReq ? ST_INTR : ST_FETCH;
            end

            ST_INTR: begin
                pc_write    = 1'b1;
                int_taken   = 1'b1;
                w_stateNext = ST_FETCH;
            end

            default: begin
                w_stateNext = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// tb_otter_cu_fsm: directed bench for the OTTER control-unit sequencer.
// Each instruction is expanded into its per-cycle strobe pattern, and the
// DUT is compared against that pattern once per cycle on the falling edge.
module tb_otter_cu_fsm;

    localparam int INIT_CYCLES = 3;

    // Output vector bit order:
    // {pc_write, reg_write, mem_rden1, mem_rden2, mem_we2, csr_we, mret_exec, int_taken, rst_out}
    localparam logic [8:0] V_RST   = 9'h001;
    localparam logic [8:0] V_FETCH = 9'h040;
    localparam logic [8:0] V_WB    = 9'h180;
    localparam logic [8:0] V_INTR  = 9'h102;
    localparam logic [8:0] NOPIN   = 9'h1FF;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       intr;
    logic       csr_mie;
    logic       pc_write, reg_write, mem_rden1, mem_rden2, mem_we2;
    logic       csr_we, mret_exec, int_taken, rst_out;
    logic [8:0] dutVec;

    logic [8:0] expQ[$];
    int         checks   = 0;
    int         failures = 0;

    otter_cu_fsm #(.INIT_CYCLES(INIT_CYCLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .opcode   (opcode),
        .func3    (func3),
        .intr     (intr),
        .csr_mie  (csr_mie),
        .pc_write (pc_write),
        .reg_write(reg_write),
        .mem_rden1(mem_rden1),
        .mem_rden2(mem_rden2),
        .mem_we2  (mem_we2),
        .csr_we   (csr_we),
        .mret_exec(mret_exec),
        .int_taken(int_taken),
        .rst_out  (rst_out)
    );

    assign dutVec = {pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
                     csr_we, mret_exec, int_taken, rst_out};

    // Free-running clock: rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Strobes an instruction must raise in its execute cycle, straight from the opcode table.
    function automatic logic [8:0] execVec(input logic [6:0] op, input logic [2:0] f3);
        logic [8:0] v;
        case (op)
            7'b0110111, 7'b0010111, 7'b1101111,
            7'b1100111, 7'b0010011, 7'b0110011: v = 9'h180;
            7'b1100011:                         v = 9'h100;
            7'b0100011:                         v = 9'h110;
            7'b0000011:                         v = 9'h020;
            7'b1110011: begin
                if (f3 == 3'b001)      v = 9'h188;
                else if (f3 == 3'b000) v = 9'h104;
                else                   v = 9'h100;
            end
            default:                            v = 9'h100;
        endcase
        return v;
    endfunction

    // Immediate literal comparison of the DUT outputs.
    task automatic checkOutput(input string nm, input logic [8:0] want);
        checks++;
        if (dutVec !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %b, want %b at %0t", nm, dutVec, want, $time);
        end
    endtask

    // Queue the expected vector for the current cycle, optionally pin it, then advance one cycle.
    task automatic applyStimulus(input logic [8:0] vec, input logic [8:0] pin, input string nm);
        expQ.push_back(vec);
        if (pin != NOPIN) begin
            #2;
            checkOutput(nm, pin);
        end
        @(posedge clk);
        #1;
    endtask

    // One full instruction: fetch, execute, optional writeback, optional interrupt entry.
    task automatic runInstr(input logic [6:0] op, input logic [2:0] f3,
                            input logic intrF, input logic intrL, input logic mie,
                            input logic [8:0] pinExec, input string nm);
        opcode  = op;
        func3   = f3;
        csr_mie = mie;
        intr    = intrF;
        applyStimulus(V_FETCH, NOPIN, nm);
        intr = intrL;
        applyStimulus(execVec(op, f3), pinExec, nm);
        if (op == 7'b0000011)
            applyStimulus(V_WB, NOPIN, nm);
        if (intrL && mie)
            applyStimulus(V_INTR, V_INTR, {nm, "_intr"});
    endtask

    // Hold reset for two cycles, then release and expect INIT_CYCLES reset cycles.
    task automatic resetSequence(input string nm);
        rst_n = 1'b0;
        applyStimulus(V_RST, V_RST, {nm, "_held"});
        applyStimulus(V_RST, NOPIN, nm);
        rst_n = 1'b1;
        for (int i = 0; i < INIT_CYCLES; i++)
            applyStimulus(V_RST, NOPIN, nm);
    endtask

    // Per-cycle compare against the expected queue plus the one-memory-strobe invariant.
    always @(negedge clk) begin
        logic [8:0] want;
        if (expQ.size() > 0) begin
            want = expQ.pop_front();
            checks++;
            if (dutVec !== want) begin
                failures++;
                $display("[TB] FAIL cycle: got %b, want %b at %0t", dutVec, want, $time);
            end
            checks++;
            if ((32'(mem_rden1) + 32'(mem_rden2) + 32'(mem_we2)) > 1) begin
                failures++;
                $display("[TB] FAIL memStrobes: got rden1=%b rden2=%b we2=%b, want at most one high",
                         mem_rden1, mem_rden2, mem_we2);
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario list.
    initial begin
        rst_n   = 1'b0;
        opcode  = 7'd0;
        func3   = 3'd0;
        intr    = 1'b0;
        csr_mie = 1'b0;
        @(posedge clk);
        #1;

        resetSequence("reset");

        // First fetch after INIT, then a steady ADDI stream.
        runInstr(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 9'h180, "addi");
        for (int i = 0; i < 3; i++)
            runInstr(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, NOPIN, "addiLoop");

        runInstr(7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 9'h020, "lw");
        runInstr(7'b0100011, 3'd2, 1'b1, 1'b1, 1'b1, 9'h110, "swIntr");

        // Masked interrupt must never be taken.
        for (int i = 0; i < 10; i++)
            runInstr(7'b0010011, 3'd0, 1'b1, 1'b1, 1'b0, NOPIN, "addiMasked");

        runInstr(7'b1110011, 3'b001, 1'b0, 1'b0, 1'b1, 9'h188, "csrrw");
        runInstr(7'b1110011, 3'b000, 1'b0, 1'b0, 1'b1, 9'h104, "mret");
        runInstr(7'b1110011, 3'b000, 1'b1, 1'b1, 1'b1, 9'h104, "mretIntr");
        runInstr(7'b1110011, 3'b010, 1'b0, 1'b0, 1'b0, 9'h100, "sysOther");
        runInstr(7'b1100011, 3'd0, 1'b0, 1'b0, 1'b0, 9'h100, "branch");
        runInstr(7'b1111111, 3'd0, 1'b0, 1'b0, 1'b0, 9'h100, "nop");
        runInstr(7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, NOPIN, "lui");
        runInstr(7'b0010111, 3'd0, 1'b0, 1'b0, 1'b0, NOPIN, "auipc");
        runInstr(7'b1101111, 3'd0, 1'b0, 1'b1, 1'b1, NOPIN, "jalIntr");
        runInstr(7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, NOPIN, "jalr");
        runInstr(7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, NOPIN, "add");

        // Request only during fetch is not latched.
        runInstr(7'b0010011, 3'd0, 1'b1, 1'b0, 1'b1, NOPIN, "fetchOnlyIntr");

        // Load with a pending interrupt completes writeback first.
        runInstr(7'b0000011, 3'd2, 1'b0, 1'b1, 1'b1, NOPIN, "lwIntr");

        // Interrupt still pending with MIE on: taken again after the next instruction.
        runInstr(7'b0010011, 3'd0, 1'b1, 1'b1, 1'b1, NOPIN, "addiRepeatIntr");

        // Reset dropped in the middle of a load's writeback.
        intr    = 1'b0;
        csr_mie = 1'b0;
        opcode  = 7'b0000011;
        func3   = 3'd2;
        applyStimulus(V_FETCH, NOPIN, "lwAbort");
        applyStimulus(9'h020, NOPIN, "lwAbort");
        rst_n = 1'b0;
        applyStimulus(V_RST, V_RST, "lwAbortWb");
        applyStimulus(V_RST, NOPIN, "lwAbort");
        rst_n = 1'b1;
        for (int i = 0; i < INIT_CYCLES; i++)
            applyStimulus(V_RST, NOPIN, "lwAbortInit");
        runInstr(7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 9'h180, "addiAfterAbort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
- Sequencing half of the OTTER control unit. The combinational decoder chooses *what* each instruction does (ALU function, mux selects, pcSource). This block decides *when* it happens.
- Steps each instruction through fetch / execute / writeback and issues the write and read strobes.
- Accepts gated interrupts between instructions and drives `int_taken` back to the decoder, which forces pcSource to the interrupt vector.

Parameters:
- INIT_CYCLES, 1, number of cycles held in ST_INIT (`rst_out` asserted) after reset release; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  7  ir[6:0] of the current instruction; valid from ST_EXEC onward.
- func3  input  3  ir[14:12].
- intr  input  1  external interrupt request, level, synchronous to clk.
- csr_mie  input  1  interrupt enable from the CSR file.
- pc_write  output  1  PC register load enable.
- reg_write  output  1  register file write enable.
- mem_rden1  output  1  instruction memory read enable.
- mem_rden2  output  1  data memory read enable.
- mem_we2  output  1  data memory write enable.
- csr_we  output  1  CSR file write enable (csrrw).
- mret_exec  output  1  restores MIE/PC from CSRs (mret).
- int_taken  output  1  interrupt accepted; to the decoder and the CSR file.
- rst_out  output  1  synchronous reset to PC and datapath.

Behaviour:
- States: ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_INTR. State and the INIT counter are the only flops.
- All outputs are combinational from the current state plus opcode/func3 (Moore with respect to state). Every output defaults to 0 in every state unless listed below.
- Reset (rst_n=0, asynchronous):
  - state=ST_INIT, INIT counter=0.
  - Outputs while held: `rst_out`=1, all others 0.
  - Asserting rst_n low in any state aborts the instruction immediately; no partial strobes are issued afterward.
- ST_INIT:
  - `rst_out`=1.
  - Counter increments each cycle; moves to ST_FETCH after exactly INIT_CYCLES cycles, then the counter clears.
- ST_FETCH:
  - `mem_rden1`=1.
  - Always moves to ST_EXEC; instruction data is valid one cycle later.
- ST_EXEC, by opcode:
  - LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, OP_IMM 0010011, OP_RG3 0110011: `pc_write`=1, `reg_write`=1.
  - BRANCH 1100011: `pc_write`=1 only (taken/not-taken is resolved by the decoder's pcSource).
  - STORE 0100011: `pc_write`=1, `mem_we2`=1.
  - LOAD 0000011: `mem_rden2`=1, `pc_write`=0; moves to ST_WB.
  - SYS 1110011, func3=001 (csrrw): `pc_write`=1, `reg_write`=1, `csr_we`=1.
  - SYS, func3=000 (mret): `pc_write`=1, `mret_exec`=1.
  - SYS, other func3: `pc_write`=1 only.
  - Any other opcode: executes as a NOP with `pc_write`=1 only; no write strobes.
- ST_WB (loads only): `pc_write`=1, `reg_write`=1.
- Interrupt acceptance:
  - Define intr_req = intr & csr_mie, sampled at the last cycle of an instruction: ST_EXEC for non-loads, ST_WB for loads.
  - intr_req=1 → ST_INTR; otherwise → ST_FETCH.
  - An instruction is never interrupted mid-way; a load always completes WB before the interrupt is taken.
- ST_INTR:
  - `int_taken`=1, `pc_write`=1 (PC loads the vector, mepc is captured); lasts one cycle, then → ST_FETCH.
  - intr still high at that point does not re-enter ST_INTR, because the CSR file clears MIE on `int_taken`.
  - If csr_mie is still 1, the next interrupt is taken only after the following instruction completes.
- mret combined with intr_req in the same ST_EXEC: `mret_exec` and `pc_write` are issued this cycle, then the FSM goes to ST_INTR next cycle.
- Interrupts arriving in ST_INIT or ST_FETCH are not latched; only the level at the sample point matters.
- Invariant: at most one of `mem_we2`, `mem_rden2`, `mem_rden1` is high in any cycle.

Test Plan:
- Reset, INIT_CYCLES=3: hold rst_n=0 for 2 cycles, release → `rst_out`=1 for exactly 3 cycles, then `mem_rden1`=1 on the next cycle; all other outputs 0 throughout.
- ADDI (opcode 0010011), intr=0 → FETCH (`mem_rden1`) then EXEC (`pc_write`=1, `reg_write`=1), back to FETCH; repeats with a 2-cycle period.
- LW (opcode 0000011) → EXEC `mem_rden2`=1 with `pc_write`=0, then WB `pc_write`=1 and `reg_write`=1; 3-cycle instruction.
- SW (opcode 0100011) with intr=1 and csr_mie=1 → EXEC `mem_we2`=1, `pc_write`=1; next cycle `int_taken`=1, `pc_write`=1; then FETCH.
- intr=1 with csr_mie=0 across 10 ADDIs → `int_taken` never asserts.
- csrrw (1110011, func3=001) → `csr_we`, `reg_write`, `pc_write` all 1 in EXEC.
- mret (func3=000) → `mret_exec`=1 in EXEC.
- Drop rst_n mid-ST_WB of a load → same cycle `reg_write`=0 and `rst_out`=1.
